// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 core scheduler and its arbiter.
package sha256_pkg;

    localparam int BLOCK_W  = 512;
    localparam int DIGEST_W = 256;

    localparam logic [DIGEST_W-1:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BUSY,
        ST_OUTPUT
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester after last_grant
// (modulo NREQ) wins.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any
);

    always_comb begin
        int idx;
        // NOTE: every output gets a default before the loop so no path leaves a latch.
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        // Scan farthest-first so the nearest requester after last_grant overwrites the rest.
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (req[idx[IDW-1:0]]) begin
                grant     = NREQ'(1) << idx;
                grant_idx = idx[IDW-1:0];
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha256_core_scheduler.sv
// Time-shares one SHA-256 compression core between NREQ message streams,
// keeping a chaining value and block count per requester.
module sha256_core_scheduler
    import sha256_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_first,
    input  logic [NREQ-1:0]         req_last,
    input  logic [NREQ*BLOCK_W-1:0] req_block,
    output logic [NREQ-1:0]         req_ready,
    output logic                    core_start,
    output logic [BLOCK_W-1:0]      core_block,
    output logic [DIGEST_W-1:0]     core_chain,
    input  logic                    core_done,
    input  logic [DIGEST_W-1:0]     core_digest,
    output logic                    dig_valid,
    input  logic                    dig_ready,
    output logic [IDW-1:0]          dig_id,
    output logic [DIGEST_W-1:0]     dig_data,
    output logic [CNTW-1:0]         dig_nblocks,
    output logic                    busy
);

    sched_state_e          state;
    logic [IDW-1:0]        last_grant;
    logic [IDW-1:0]        gid;
    logic [BLOCK_W-1:0]    blk_q;
    logic [DIGEST_W-1:0]   chain_q;
    logic                  first_q;
    logic                  last_q;
    logic [DIGEST_W-1:0]   chain [NREQ];
    logic [CNTW-1:0]       cnt   [NREQ];

    logic [NREQ-1:0]       arb_grant;
    logic [IDW-1:0]        arb_idx;
    logic                  arb_any;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .any        (arb_any)
    );

    // The core reads the captured block/chain directly; both hold until the next grant.
    assign core_block = blk_q;
    assign core_chain = chain_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            last_grant  <= IDW'(NREQ - 1);
            gid         <= '0;
            blk_q       <= '0;
            chain_q     <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            req_ready   <= '0;
            core_start  <= 1'b0;
            dig_valid   <= 1'b0;
            dig_id      <= '0;
            dig_data    <= '0;
            dig_nblocks <= '0;
            busy        <= 1'b0;
            // NOTE: chain/cnt are a handful of flops, not a RAM, so they can and must reset to IV/0.
            for (int i = 0; i < NREQ; i++) begin
                chain[i] <= SHA256_IV;
                cnt[i]   <= '0;
            end
        end else begin
            req_ready  <= '0;
            core_start <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        gid        <= arb_idx;
                        last_grant <= arb_idx;
                        blk_q      <= req_block[arb_idx*BLOCK_W +: BLOCK_W];
                        first_q    <= req_first[arb_idx];
                        last_q     <= req_last[arb_idx];
                        chain_q    <= req_first[arb_idx] ? SHA256_IV : chain[arb_idx];
                        req_ready  <= arb_grant;
                        core_start <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt[gid] <= first_q ? CNTW'(1) : cnt[gid] + CNTW'(1);
                    state    <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (core_done) begin
                        if (last_q) begin
                            dig_valid   <= 1'b1;
                            dig_id      <= gid;
                            dig_data    <= core_digest;
                            dig_nblocks <= cnt[gid];
                            chain[gid]  <= SHA256_IV;
                            state       <= ST_OUTPUT;
                        end else begin
                            chain[gid]  <= core_digest;
                            busy        <= 1'b0;
                            state       <= ST_IDLE;
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (dig_ready) begin
                        dig_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_core_scheduler.sv
// Directed bench for sha256_core_scheduler with a behavioural SHA-256 core,
// per-requester block feeders and a digest sink with programmable backpressure.
module tb_sha256_core_scheduler;
    import sha256_pkg::*;

    localparam int NREQ     = 4;
    localparam int IDW      = 2;
    localparam int CNTW     = 32;
    localparam int CORE_LAT = 3;

    localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] TWO_B0  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] TWO_B1  = {{15{32'h0}}, 32'h000001c0};
    localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NREQ-1:0]         req_valid, req_first, req_last, req_ready;
    logic [NREQ*BLOCK_W-1:0] req_block;
    logic                    core_start, core_done;
    logic [BLOCK_W-1:0]      core_block;
    logic [DIGEST_W-1:0]     core_chain, core_digest;
    logic                    dig_valid, dig_ready, busy;
    logic [IDW-1:0]          dig_id;
    logic [DIGEST_W-1:0]     dig_data;
    logic [CNTW-1:0]         dig_nblocks;

    always #5 clk = ~clk;

    sha256_core_scheduler #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_first(req_first), .req_last(req_last),
        .req_block(req_block), .req_ready(req_ready),
        .core_start(core_start), .core_block(core_block), .core_chain(core_chain),
        .core_done(core_done), .core_digest(core_digest),
        .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_id(dig_id),
        .dig_data(dig_data), .dig_nblocks(dig_nblocks), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96]  + e, hin[95:64]   + f, hin[63:32]   + g, hin[31:0]    + hh};
    endfunction

    // Per-requester block queues, replayed by the feeder until each block is accepted.
    typedef struct packed {
        logic         first;
        logic         last;
        logic [511:0] blk;
    } item_t;

    item_t qmem [NREQ][8];
    int    qhead [NREQ];
    int    qtail [NREQ];

    task automatic push(input int id, input logic f, input logic l, input logic [511:0] b);
        qmem[id][qtail[id]] = '{first: f, last: l, blk: b};
        qtail[id]++;
    endtask

    task automatic push_msg(input int id, input logic two, input logic first_flag);
        if (two) begin
            push(id, first_flag, 1'b0, TWO_B0);
            push(id, 1'b0, 1'b1, TWO_B1);
        end else begin
            push(id, first_flag, 1'b1, ABC_BLK);
        end
    endtask

    task automatic clear_queues();
        for (int i = 0; i < NREQ; i++) begin
            qhead[i] = 0;
            qtail[i] = 0;
        end
    endtask

    initial begin
        req_valid = '0; req_first = '0; req_last = '0; req_block = '0;
        clear_queues();
        forever begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] && qhead[i] < qtail[i]) qhead[i]++;
                if (qhead[i] < qtail[i]) begin
                    req_valid[i]          = 1'b1;
                    req_first[i]          = qmem[i][qhead[i]].first;
                    req_last[i]           = qmem[i][qhead[i]].last;
                    req_block[i*512 +: 512] = qmem[i][qhead[i]].blk;
                end else begin
                    req_valid[i]          = 1'b0;
                    req_first[i]          = 1'b0;
                    req_last[i]           = 1'b0;
                    req_block[i*512 +: 512] = '0;
                end
            end
        end
    end

    // Behavioural compression core: fixed latency, chain_in + compress(chain_in, block).
    int             pend = 0;
    bit             stray = 0;
    logic [511:0]   cap_blk;
    logic [255:0]   cap_chain, cap_dig;

    initial begin
        core_done = 1'b0;
        core_digest = '0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (!rst_n) begin
                pend = 0;
                stray = 0;
            end else begin
                if (stray) begin
                    stray = 0;
                    core_done = 1'b1;
                    core_digest = {8{32'hdeadbeef}};
                end
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        check("core_block_stable", core_block, cap_blk);
                        check("core_chain_stable", core_chain, cap_chain);
                        core_digest = cap_dig;
                        core_done = 1'b1;
                    end
                end
                if (core_start) begin
                    cap_blk   = core_block;
                    cap_chain = core_chain;
                    cap_dig   = sha_compress(core_chain, core_block);
                    pend      = CORE_LAT;
                end
            end
        end
    end

    // Grant monitor: logs the accept order and checks start/ready pairing.
    logic [IDW-1:0] glog [32];
    int             gcnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (core_start || req_ready != '0) begin
                check("start_with_ready", core_start, |req_ready);
                check("ready_onehot", $onehot(req_ready), 1);
                for (int i = 0; i < NREQ; i++)
                    if (req_ready[i] && gcnt < 32) begin
                        glog[gcnt] = IDW'(i);
                        gcnt++;
                    end
            end
        end
    end

    // Digest sink with optional stall; records each accepted digest.
    int              stall = 0;
    int              rcnt = 0;
    logic [IDW-1:0]  r_id [16];
    logic [255:0]    r_data [16];
    logic [CNTW-1:0] r_n [16];
    bit              idle_next = 0;
    bit              held_ok = 0;
    logic [255:0]    held;

    initial begin
        dig_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (idle_next) begin
                idle_next = 0;
                check("idle_after_handshake", {busy, dig_valid}, 0);
            end
            if (held_ok) begin
                check("held_valid", dig_valid, 1);
                check("held_data", dig_data, held);
                check("no_issue_in_output", {core_start, req_ready}, 0);
                if (!dig_valid) begin
                    held_ok = 0;
                    stall = 0;
                end
            end
            if (rst_n && dig_valid) begin
                if (stall > 0) begin
                    if (!held_ok) begin
                        held = dig_data;
                        held_ok = 1;
                    end
                    dig_ready = 1'b0;
                    stall--;
                end else begin
                    held_ok = 0;
                    if (rcnt < 16) begin
                        r_id[rcnt]   = dig_id;
                        r_data[rcnt] = dig_data;
                        r_n[rcnt]    = dig_nblocks;
                    end
                    rcnt++;
                    dig_ready = 1'b1;
                    idle_next = 1;
                end
            end
        end
    end

    task automatic wait_results(input int n, input string name);
        int budget = 400;
        while (rcnt < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check({name, "_digest_count"}, rcnt, n);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {req_ready, core_start, dig_valid, busy, dig_id, dig_nblocks}, 0);
        check({tag, "_core_block"}, core_block, 0);
        check({tag, "_core_chain"}, core_chain, 0);
        check({tag, "_dig_data"}, dig_data, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_queues();
        stall = 0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        rcnt = 0;
        gcnt = 0;
    endtask

    typedef struct packed {
        logic [1:0]   id;
        logic         two;
        logic         first;
        logic [255:0] exp_dig;
        logic [31:0]  exp_n;
    } vec_t;

    initial begin
        vec_t vecs [5];
        int   budget;
        vecs[0] = '{id: 2'd0, two: 1'b0, first: 1'b1, exp_dig: ABC_DIG, exp_n: 32'd1};
        vecs[1] = '{id: 2'd2, two: 1'b1, first: 1'b1, exp_dig: TWO_DIG, exp_n: 32'd2};
        vecs[2] = '{id: 2'd3, two: 1'b0, first: 1'b1, exp_dig: ABC_DIG, exp_n: 32'd1};
        // No first flag after a finished message: chain is back at IV, count keeps running.
        vecs[3] = '{id: 2'd3, two: 1'b0, first: 1'b0, exp_dig: ABC_DIG, exp_n: 32'd2};
        vecs[4] = '{id: 2'd1, two: 1'b1, first: 1'b1, exp_dig: TWO_DIG, exp_n: 32'd2};

        do_reset();

        for (int v = 0; v < 5; v++) begin
            clear_queues();
            rcnt = 0;
            push_msg(int'(vecs[v].id), vecs[v].two, vecs[v].first);
            wait_results(1, $sformatf("vec%0d", v));
            check($sformatf("vec%0d_id", v), r_id[0], vecs[v].id);
            check($sformatf("vec%0d_data", v), r_data[0], vecs[v].exp_dig);
            check($sformatf("vec%0d_nblocks", v), r_n[0], vecs[v].exp_n);
        end

        // All four requesters with two-block messages from reset: strict rotation.
        do_reset();
        for (int i = 0; i < NREQ; i++) push_msg(i, 1'b1, 1'b1);
        wait_results(4, "rr4");
        check("rr4_grant_count", gcnt, 8);
        for (int i = 0; i < 8; i++) check($sformatf("rr4_grant%0d", i), glog[i], i % NREQ);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr4_id%0d", i), r_id[i], i);
            check($sformatf("rr4_data%0d", i), r_data[i], TWO_DIG);
            check($sformatf("rr4_n%0d", i), r_n[i], 2);
        end

        // Backpressure: first digest stalled 10 cycles while requester 1 waits.
        clear_queues();
        rcnt = 0;
        stall = 10;
        push_msg(0, 1'b0, 1'b1);
        push_msg(1, 1'b0, 1'b1);
        wait_results(2, "bp");
        check("bp_stall_consumed", stall, 0);
        check("bp_id0", r_id[0], 0);
        check("bp_id1", r_id[1], 1);
        check("bp_data0", r_data[0], ABC_DIG);
        check("bp_data1", r_data[1], ABC_DIG);

        // Abandon: a fresh first block discards the half-done message.
        clear_queues();
        rcnt = 0;
        push(1, 1'b1, 1'b0, TWO_B0);
        push(1, 1'b1, 1'b1, ABC_BLK);
        wait_results(1, "abandon");
        check("abandon_id", r_id[0], 1);
        check("abandon_data", r_data[0], ABC_DIG);
        check("abandon_nblocks", r_n[0], 1);

        // Stray core_done while idle must be ignored.
        clear_queues();
        rcnt = 0;
        stray = 1;
        repeat (3) @(negedge clk);
        check("stray_done_ignored", {busy, dig_valid}, 0);
        check("stray_no_digest", rcnt, 0);
        push_msg(2, 1'b0, 1'b1);
        wait_results(1, "after_stray");
        check("after_stray_data", r_data[0], ABC_DIG);
        check("after_stray_nblocks", r_n[0], 1);

        // Reset during BUSY, then requester 0 must win against requester 3.
        clear_queues();
        push_msg(2, 1'b1, 1'b1);
        budget = 100;
        while (!req_ready[2] && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("midrst_granted", req_ready[2], 1);
        @(negedge clk);
        check("midrst_busy_before", busy, 1);
        rst_n = 1'b0;
        clear_queues();
        @(negedge clk);
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        rcnt = 0;
        gcnt = 0;
        push_msg(3, 1'b0, 1'b1);
        push_msg(0, 1'b0, 1'b1);
        wait_results(2, "postrst");
        check("postrst_first_grant", glog[0], 0);
        check("postrst_id0", r_id[0], 0);
        check("postrst_id1", r_id[1], 3);
        check("postrst_data0", r_data[0], ABC_DIG);
        check("postrst_data1", r_data[1], ABC_DIG);
        check("postrst_n0", r_n[0], 1);
        check("postrst_n1", r_n[1], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
